// File: rtl/fm_demod_pkg.sv
// Shared constants for the FM distance receiver: FSM state encoding and default
// conversion/timing parameters.
package fm_demod_pkg;

    typedef logic [0:0] fm_state_t;

    localparam fm_state_t StIdle    = 1'b0;
    localparam fm_state_t StMeasure = 1'b1;

    localparam int unsigned DefTimeoutCycles = 2048;
    localparam int unsigned DefMinPeriod     = 120;
    localparam int unsigned DefCntMinDist    = 11034;
    localparam int unsigned DefScaleQ8       = 720;
    localparam int unsigned DefMaxDist       = 2000;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse.
module edge_sync
    import fm_demod_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/fm_demod.sv
// FM carrier period demodulator: accumulates 2^N_PERIODS_LOG2 carrier periods and
// converts the total into a clamped distance. Optional FM_DEMOD_GLITCH_FILTER_EN.
module fm_demod
    import fm_demod_pkg::*;
#(
    parameter int unsigned WIDTH          = 13,
    parameter int unsigned N_PERIODS_LOG2 = 6,
    parameter int unsigned ACC_WIDTH      = 20,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned MIN_PERIOD     = DefMinPeriod,
    parameter int unsigned CNT_MIN_DIST   = DefCntMinDist,
    parameter int unsigned SCALE_Q8       = DefScaleQ8,
    parameter int unsigned MAX_DIST       = DefMaxDist
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             fm_in,
    output logic [WIDTH-1:0] distance,
    output logic             valid,
    output logic             lock,
    output logic             timeout
);

    localparam int unsigned PcntW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned ProdW = ACC_WIDTH + 16;

    localparam logic [PcntW-1:0]     PcntLast = PcntW'(TIMEOUT_CYCLES - 1);
    localparam logic [PcntW-1:0]     PcntOne  = PcntW'(1);
    localparam logic [N_PERIODS_LOG2-1:0] IdxOne = N_PERIODS_LOG2'(1);
    localparam logic [ACC_WIDTH-1:0] CntMin   = ACC_WIDTH'(CNT_MIN_DIST);
    localparam logic [ProdW-1:0]     ScaleW   = ProdW'(SCALE_Q8);
    localparam logic [ProdW-1:0]     MaxDistW = ProdW'(MAX_DIST);
    localparam logic [WIDTH-1:0]     MaxDistO = WIDTH'(MAX_DIST);

`ifdef FM_DEMOD_GLITCH_FILTER_EN
    localparam logic GlitchEn = 1'b1;
`else
    localparam logic GlitchEn = 1'b0;
`endif

    logic edge_pulse;

    edge_sync u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (fm_in),
        .rise    (edge_pulse)
    );

    fm_state_t                 state_q, state_d;
    logic [PcntW-1:0]          pcnt_q, pcnt_d;
    logic [ACC_WIDTH-1:0]      acc_q, acc_d;
    logic [N_PERIODS_LOG2-1:0] idx_q, idx_d;

    logic                      s1_valid_q;
    logic [ACC_WIDTH-1:0]      s1_diff_q;
    logic                      valid_q;
    logic [WIDTH-1:0]          distance_q;
    logic                      lock_q;

    logic                      accept;
    logic                      win_done;
    logic                      timeout_c;
    logic [31:0]               period_len;
    logic [ACC_WIDTH:0]        acc_sum_wide;
    logic [ACC_WIDTH-1:0]      acc_sum;
    logic [ACC_WIDTH-1:0]      diff;
    logic [ProdW-1:0]          scaled;
    logic [WIDTH-1:0]          clamped;

    assign period_len = 32'(pcnt_q) + 32'd1;

    // Short periods only exist as comparator chatter; they are dropped without
    // disturbing the running period count.
    assign accept = edge_pulse & (~GlitchEn | (period_len >= MIN_PERIOD));

    assign acc_sum_wide = {1'b0, acc_q} + (ACC_WIDTH + 1)'(pcnt_q) + (ACC_WIDTH + 1)'(1);
    assign acc_sum      = acc_sum_wide[ACC_WIDTH] ? '1 : acc_sum_wide[ACC_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        win_done  = 1'b0;
        timeout_c = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            pcnt_d  = '0;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    pcnt_d = '0;
                    acc_d  = '0;
                    idx_d  = '0;
                    if (edge_pulse) begin
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    if (accept) begin
                        pcnt_d = '0;
                        idx_d  = idx_q + IdxOne;
                        if (idx_q == '1) begin
                            // Closing edge also opens the next window.
                            win_done = 1'b1;
                            acc_d    = '0;
                        end else begin
                            acc_d = acc_sum;
                        end
                    end else if (pcnt_q == PcntLast) begin
                        timeout_c = 1'b1;
                        state_d   = StIdle;
                        pcnt_d    = '0;
                        acc_d     = '0;
                        idx_d     = '0;
                    end else begin
                        pcnt_d = pcnt_q + PcntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pcnt_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign diff    = (acc_sum >= CntMin) ? '0 : (CntMin - acc_sum);
    assign scaled  = (ProdW'(s1_diff_q) * ScaleW) >> 8;
    assign clamped = (scaled > MaxDistW) ? MaxDistO : scaled[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            valid_q    <= 1'b0;
            distance_q <= '0;
            lock_q     <= 1'b0;
        end else if (!enable) begin
            s1_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            s1_valid_q <= win_done;
            if (win_done) begin
                s1_diff_q <= diff;
            end
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                distance_q <= clamped;
            end
            if (timeout_c) begin
                lock_q <= 1'b0;
            end else if (s1_valid_q) begin
                lock_q <= 1'b1;
            end
        end
    end

    assign distance = distance_q;
    assign valid    = valid_q;
    assign lock     = lock_q;
    assign timeout  = timeout_c;

endmodule

// File: tb/tb_fm_demod.sv
// Directed testbench for fm_demod: carrier periods, timeout, reset, enable, glitch.
module tb_fm_demod;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        fm_in;
    logic [12:0] distance;
    logic        valid;
    logic        lock;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nto      = 0;
    int tocyc    = 0;
    int vq[$];
    int dq[$];
    int rq[$];

    fm_demod dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .fm_in    (fm_in),
        .distance (distance),
        .valid    (valid),
        .lock     (lock),
        .timeout  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are sampled at the falling edge; inputs change right after sampling.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            vq.push_back(cyc);
            dq.push_back(int'(distance));
        end
        if (timeout === 1'b1) begin
            nto++;
            tocyc = cyc;
        end
    endtask

    task automatic clear_logs();
        vq.delete();
        dq.delete();
        rq.delete();
        nto = 0;
    endtask

    // Each rise is followed by exactly one full period; the optional glitch is a
    // 3-clk high pulse 4 clk into the low half.
    task automatic carrier(input int period, input int nrise, input bit glitch);
        for (int k = 0; k < nrise; k++) begin
            for (int i = 0; i < period; i++) begin
                tick();
                if (i == 0) rq.push_back(cyc);
                if (i < period / 2) fm_in = 1'b1;
                else if (glitch && i >= period / 2 + 4 && i < period / 2 + 7) fm_in = 1'b1;
                else fm_in = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        fm_in   = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        clear_logs();
    endtask

    task automatic test_reset();
        fm_in   = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (distance !== 13'd0) begin failures++; $display("FAIL reset_distance got %0d want 0", distance); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock got %b want 0", lock); end
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b want 0", timeout); end
        reset_n = 1'b1;
        repeat (2) tick();
        clear_logs();
    endtask

    // 168 clk * 64 = 10752 -> diff 282 -> 282*720/256 = 793
    task automatic test_period_168();
        carrier(168, 64, 1'b0);
        checks++;
        if (vq.size() != 0 || lock !== 1'b0) begin
            failures++; $display("FAIL p168_prelock valids %0d lock %b want 0 0", vq.size(), lock);
        end
        carrier(168, 65, 1'b0);
        checks++;
        if (vq.size() != 2) begin
            failures++; $display("FAIL p168_valid_count got %0d want 2", vq.size());
        end else begin
            checks++;
            if (vq[0] != rq[64] + 5) begin
                failures++; $display("FAIL p168_first_latency got %0d want %0d", vq[0], rq[64] + 5);
            end
            checks++;
            if (vq[1] != rq[128] + 5 || vq[1] - vq[0] != 64 * 168) begin
                failures++; $display("FAIL p168_back_to_back got %0d want %0d", vq[1], rq[128] + 5);
            end
            checks++;
            if (dq[0] != 793 || dq[1] != 793) begin
                failures++; $display("FAIL p168_distance got %0d,%0d want 793", dq[0], dq[1]);
            end
        end
        checks++;
        if (lock !== 1'b1) begin failures++; $display("FAIL p168_lock got %b want 1", lock); end
    endtask

    task automatic test_timeout();
        int last_rise;
        last_rise = rq[rq.size() - 1];
        clear_logs();
        fm_in = 1'b0;
        repeat (2100) tick();
        checks++;
        if (nto != 1) begin
            failures++; $display("FAIL timeout_count got %0d want 1", nto);
        end else begin
            checks++;
            if (tocyc != last_rise + 3 + 2048) begin
                failures++; $display("FAIL timeout_cycle got %0d want %0d", tocyc, last_rise + 3 + 2048);
            end
        end
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL timeout_lock got %b want 0", lock); end
        checks++;
        if (vq.size() != 0) begin failures++; $display("FAIL timeout_valid got %0d want 0", vq.size()); end
        checks++;
        if (distance !== 13'd793) begin
            failures++; $display("FAIL timeout_hold got %0d want 793", distance);
        end
    endtask

    // 172 clk * 64 = 11008 -> diff 26 -> 26*720/256 = 73
    task automatic test_reset_mid();
        clear_logs();
        carrier(168, 31, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (distance !== 13'd0 || valid !== 1'b0 || lock !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got d=%0d v=%b l=%b t=%b want 0 0 0 0",
                     distance, valid, lock, timeout);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        clear_logs();
        carrier(172, 64, 1'b0);
        checks++;
        if (vq.size() != 0) begin failures++; $display("FAIL midreset_early got %0d want 0", vq.size()); end
        carrier(172, 1, 1'b0);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL midreset_valid got %0d want 1", vq.size());
        end else begin
            checks++;
            if (vq[0] != rq[64] + 5 || dq[0] != 73) begin
                failures++; $display("FAIL p172 got cyc %0d d %0d want cyc %0d d 73", vq[0], dq[0], rq[64] + 5);
            end
        end
        checks++;
        if (lock !== 1'b1) begin failures++; $display("FAIL midreset_lock got %b want 1", lock); end
    endtask

    // 175 clk * 64 = 11200 >= 11034 -> distance 0
    task automatic test_enable();
        clear_logs();
        carrier(172, 20, 1'b0);
        enable = 1'b0;
        fm_in  = 1'b0;
        repeat (10) tick();
        checks++;
        if (lock !== 1'b0) begin failures++; $display("FAIL disable_lock got %b want 0", lock); end
        checks++;
        if (vq.size() != 0 || nto != 0) begin
            failures++; $display("FAIL disable_strobes valids %0d timeouts %0d want 0 0", vq.size(), nto);
        end
        checks++;
        if (distance !== 13'd73) begin failures++; $display("FAIL disable_hold got %0d want 73", distance); end
        enable = 1'b1;
        clear_logs();
        carrier(175, 64, 1'b0);
        checks++;
        if (vq.size() != 0 || lock !== 1'b0) begin
            failures++; $display("FAIL reenable_early valids %0d lock %b want 0 0", vq.size(), lock);
        end
        carrier(175, 1, 1'b0);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL reenable_valid got %0d want 1", vq.size());
        end else begin
            checks++;
            if (vq[0] != rq[64] + 5 || dq[0] != 0) begin
                failures++; $display("FAIL p175 got cyc %0d d %0d want cyc %0d d 0", vq[0], dq[0], rq[64] + 5);
            end
        end
        checks++;
        if (lock !== 1'b1) begin failures++; $display("FAIL reenable_lock got %b want 1", lock); end
    endtask

    // 161 clk * 64 = 10304 -> diff 730 -> 2053 -> clamp 2000
    task automatic test_period_161();
        apply_reset();
        carrier(161, 65, 1'b0);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL p161_valid got %0d want 1", vq.size());
        end else begin
            checks++;
            if (dq[0] != 2000) begin failures++; $display("FAIL p161_clamp got %0d want 2000", dq[0]); end
        end
    endtask

    // Unfiltered, each glitch is a period: 64 edges span 32 real periods (5376) -> 2000.
    task automatic test_glitch();
        int exp_n;
        int exp_d;
        int exp_rise;
`ifdef FM_DEMOD_GLITCH_FILTER_EN
        exp_n = 1; exp_d = 793; exp_rise = 64;
`else
        exp_n = 2; exp_d = 2000; exp_rise = 32;
`endif
        apply_reset();
        carrier(168, 65, 1'b1);
        checks++;
        if (vq.size() != exp_n) begin
            failures++; $display("FAIL glitch_valid_count got %0d want %0d", vq.size(), exp_n);
        end else begin
            checks++;
            if (dq[0] != exp_d || vq[0] != rq[exp_rise] + 5) begin
                failures++;
                $display("FAIL glitch_window got cyc %0d d %0d want cyc %0d d %0d",
                         vq[0], dq[0], rq[exp_rise] + 5, exp_d);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        fm_in   = 1'b0;
        test_reset();
        test_period_168();
        test_timeout();
        test_reset_mid();
        test_enable();
        test_period_161();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_demod.md
# fm_demod

Receive-side counterpart of the FM distance transmitter. Takes the comparator-squared FM carrier (nominally 290–310 kHz), measures its period over a fixed number of carrier cycles, and converts the measurement back into a 13-bit distance. Sits between the analog front-end comparator input pin and the distance display/averaging logic. Emits a one-cycle `valid` strobe per measurement window and a `lock` status.

## Interface
- `WIDTH`, 13: distance bit width
- `N_PERIODS_LOG2`, 6: log2 of carrier periods per measurement window (64)
- `ACC_WIDTH`, 20: window cycle-accumulator width
- `TIMEOUT_CYCLES`, 2048: maximum clk cycles between accepted rising edges
- `MIN_PERIOD`, 120: minimum accepted period in clk cycles (glitch filter only)
- `CNT_MIN_DIST`, 11034: window count corresponding to distance 0 (290 kHz at 50 MHz)
- `SCALE_Q8`, 720: distance per count, unsigned Q8.8
- `MAX_DIST`, 2000: output clamp ceiling

- `clk` in 1: system clock, 50 MHz
- `reset_n` in 1: asynchronous active-low reset
- `enable` in 1: synchronous run enable
- `fm_in` in 1: asynchronous square-wave carrier
- `distance` out WIDTH: last converted distance
- `valid` out 1: one-cycle strobe, `distance` updated this cycle
- `lock` out 1: at least one window completed since last IDLE entry
- `timeout` out 1: one-cycle strobe, carrier loss detected

## Operation
- `fm_in` passes a 2-flop synchronizer, then rising-edge detect; `edge` is a registered one-cycle pulse.
- FSM states IDLE, MEASURE.
  - IDLE: counters cleared. On `edge` -> MEASURE, period counter = 0, accumulator = 0, period index = 0.
  - MEASURE: period counter increments each cycle. On accepted `edge`: accumulator += period counter + 1, period counter = 0, period index += 1. On the 2^N_PERIODS_LOG2-th accepted edge the accumulator total is handed to the conversion pipeline and the next window starts on the same edge (no dead time).
  - Period counter reaching TIMEOUT_CYCLES−1 with no edge: `timeout` pulse, `lock` cleared, partial window discarded, -> IDLE.
- Conversion: diff = CNT_MIN_DIST − total, 0 if total ≥ CNT_MIN_DIST; result = (diff × SCALE_Q8) >> 8, clamped to MAX_DIST; all unsigned, product width ACC_WIDTH+16 with no truncation before the clamp.
- `lock` set with the first `valid`; cleared on timeout, `enable` low, or reset.
- `enable` low: FSM -> IDLE, counters and pipeline flushed, `valid`/`timeout` held 0, `distance` holds its last value.

## Timing
- Reset values: `distance`=0, `valid`=0, `lock`=0, `timeout`=0, FSM=IDLE.
- `edge` asserts 3 clk after the `fm_in` rise (2 sync + 1 detect).
- Pipeline: stage 1 registers diff/saturation, stage 2 registers multiply/shift/clamp; `valid` and `distance` update 2 clk after the closing `edge`.
- `edge` and timeout in the same cycle: the edge wins, no timeout.
- Reset mid-window: everything returns to reset values immediately; no `valid` from the partial window.
- The accumulator saturates at all-ones. This is unreachable with default parameters; it is kept as a safety net.

## Configuration
- `FM_DEMOD_GLITCH_FILTER_EN` defined: in MEASURE, an `edge` arriving while period counter + 1 < MIN_PERIOD is ignored. It neither resets the counter nor counts as a period.
- Not defined: every `edge` is accepted, and MIN_PERIOD is unused.

## Structure
- `fm_demod_pkg` holds the FSM state enum (IDLE, MEASURE) and the default constants (CNT_MIN_DIST, SCALE_Q8, MAX_DIST, TIMEOUT_CYCLES).
- One sub-module, `edge_sync`: 2-flop synchronizer plus registered rising-edge detector with `clk`/`reset_n`.

## Test plan
- Constant period 168 clk -> total 10752, first `valid` with `distance`=793 two cycles after the 64th edge, `lock`=1, and subsequent windows back-to-back every 64×168 clk.
- Period 172 -> `distance`=73; period 175 -> total 11200 -> `distance`=0; period 161 -> 2053 clamped to `distance`=2000.
- Carrier stopped after lock -> `timeout` pulse exactly 2048 clk after the last accepted `edge`; `lock`=0, no `valid`, `distance` holds 793.
- Period 168 with a 3-clk high glitch at mid-period: with the macro, `distance` stays 793; without it, the window closes early and `distance` ≠ 793.
- `reset_n` pulsed low at edge 30 of a window -> outputs at reset values, and the next `valid` comes only after 1 + 64 new edges.
- `enable` dropped for 10 clk mid-window -> `lock`=0, no `valid`, `distance` held; after re-enable, `lock` returns with the first full window.
